logic_truth_sweeper: RTL

- Hardware truth-table sweeper for a selectable N-input logic gate.
- On `start`, it steps the gate inputs through every combination, holding each for a programmable dwell time, and captures each result into a truth-table register.
- It is the synthesizable, parametrised successor to our single 2-input gate exercised by a fixed stimulus sequence.
- It sits beside the gate library as a self-test and characterisation block.

---
 rtl/logic_truth_sweeper.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/logic_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : logic_truth_sweeper
// Description : Steps an N_IN-input selectable gate through every input
//               combination, holding each for DWELL cycles, and captures the
//               gate output for each vector into a truth-table register.
//               Optional macro LOGIC_SWEEP_GRAY_ORDER_EN applies vectors in
//               reflected Gray order (tt is still indexed by binary value).
// Revision    : 1.0 - initial release
// ============================================================================
module logic_truth_sweeper #(
    parameter int N_IN  = 2,
    parameter int DWELL = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    output logic [N_IN-1:0]      a_vec,
    output logic                 x,
    output logic                 busy,
    output logic                 done,
    output logic                 table_valid,
    output logic [2**N_IN-1:0]   tt
);

    localparam int              C_NVEC       = 2**N_IN;
    localparam logic [15:0]     C_DWELL_LAST = 16'(DWELL - 1);
    localparam logic [N_IN:0]   C_STEP_LAST  = (N_IN+1)'(C_NVEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [N_IN:0]       step_q, step_d;
    logic [2:0]          op_q, op_d;
    logic [N_IN-1:0]     a_vec_q, a_vec_d;
    logic                x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                table_valid_q, table_valid_d;
    logic [C_NVEC-1:0]   tt_q, tt_d;

    logic                gate_val;
    logic [N_IN-1:0]     step_lo_inc;
    logic [N_IN-1:0]     next_vec;

    // Gate under test, evaluated on the currently applied vector
    always_comb begin
        gate_val = 1'b0;
        case (op_q)
            3'b000: gate_val =  (&a_vec_q);
            3'b001: gate_val =  (|a_vec_q);
            3'b010: gate_val =  (^a_vec_q);
            3'b011: gate_val = ~(&a_vec_q);
            3'b100: gate_val = ~(|a_vec_q);
            3'b101: gate_val = ~(^a_vec_q);
            3'b110: gate_val =  a_vec_q[0];
            3'b111: gate_val = ~a_vec_q[0];
        endcase
    end

    assign step_lo_inc = step_q[N_IN-1:0] + (N_IN)'(1);

`ifdef LOGIC_SWEEP_GRAY_ORDER_EN
    assign next_vec = step_lo_inc ^ (step_lo_inc >> 1);
`else
    assign next_vec = step_lo_inc;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        step_d        = step_q;
        op_d          = op_q;
        a_vec_d       = a_vec_q;
        x_d           = gate_val;
        busy_d        = busy_q;
        done_d        = 1'b0;
        table_valid_d = table_valid_q;
        tt_d          = tt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d          = op;
                    a_vec_d       = '0;
                    cnt_d         = '0;
                    step_d        = '0;
                    tt_d          = '0;
                    table_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == C_DWELL_LAST) begin
                    cnt_d           = '0;
                    tt_d[a_vec_q]   = gate_val;
                    if (step_q == C_STEP_LAST) begin
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        table_valid_d = 1'b1;
                        state_d       = S_FIN;
                    end else begin
                        step_d  = step_q + (N_IN+1)'(1);
                        a_vec_d = next_vec;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            step_q        <= '0;
            op_q          <= 3'b000;
            a_vec_q       <= '0;
            x_q           <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
            tt_q          <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            op_q          <= op_d;
            a_vec_q       <= a_vec_d;
            x_q           <= x_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            table_valid_q <= table_valid_d;
            tt_q          <= tt_d;
        end
    end

    assign a_vec       = a_vec_q;
    assign x           = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_valid = table_valid_q;
    assign tt          = tt_q;

endmodule
`default_nettype wire
